// File: rtl/decod_pkg.sv
// Shared types and helpers for the registered one-hot decoder with SCAN mode.
package decod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // onehot() is sized for the widest supported selector; callers truncate to OUT_W.
  localparam int SEL_MAX_W = 8;
  localparam int OUT_MAX_W = 1 << SEL_MAX_W;

  function automatic int out_w(input int sel_w);
    return 1 << sel_w;
  endfunction

  function automatic logic [OUT_MAX_W-1:0] onehot(input logic [SEL_MAX_W-1:0] sel);
    logic [OUT_MAX_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decod_dwell_cnt.sv
// Loadable down-counter timing the gap between SCAN beats; done at terminal count zero.
module decod_dwell_cnt #(
  parameter int DWELL = 1,
  localparam int CNT_W = $clog2(DWELL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/decod_seq_reg.sv
// Registered N-to-2^N one-hot decoder with valid/ready handshake and a SCAN walk mode.
// Optional selector parity check enabled by defining DECOD_PARITY_EN.
//
// state | meaning
// IDLE  | single-beat DIRECT decode, one-register pipeline
// SCAN  | walking one-hot through all codes, more beats still to present
// DRAIN | final SCAN beat presented, waiting for it to be consumed
module decod_seq_reg
  import decod_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int DWELL = 1
) (
  input  logic                  clk_pad,
  input  logic                  rst_n_pad,
  input  logic                  in_valid_pad,
  output logic                  in_ready_pad,
  input  logic [SEL_W-1:0]      sel_pad,
`ifdef DECOD_PARITY_EN
  input  logic                  sel_par_pad,
`endif
  input  logic                  en_pad,
  input  logic                  mode_pad,
  output logic [(1<<SEL_W)-1:0] out_pad,
  output logic                  out_valid_pad,
  input  logic                  out_ready_pad,
  output logic                  busy_pad,
  output logic                  err_pad
);

  localparam int OUT_W = out_w(SEL_W);
  localparam int CNT_W = $clog2(DWELL + 1);
  // Counter reload value: a DWELL-cycle gap means the next beat loads DWELL-1 edges after consume.
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'((DWELL > 1) ? DWELL - 2 : 0);
  localparam logic [SEL_W:0]   LAST_BEAT = (SEL_W+1)'(OUT_W - 1);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_nxt;
  logic [SEL_W:0]   beat_q;
  logic             err_q;

  logic accept, consume, par_ok, start_scan;
  logic load_direct, load_scan, present, clear_valid, dwell_load, dwell_done;

`ifdef DECOD_PARITY_EN
  assign par_ok = (sel_par_pad == ^sel_pad);
`else
  assign par_ok = 1'b1;
`endif

  assign in_ready_pad = (state_q == IDLE) && (!out_valid_q || out_ready_pad);
  assign accept       = in_valid_pad && in_ready_pad;
  assign consume      = out_valid_q && out_ready_pad;
  assign start_scan   = mode_pad && en_pad && par_ok;
  assign idx_nxt      = idx_q + 1'b1;

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_direct = 1'b0;
    load_scan   = 1'b0;
    present     = 1'b0;
    clear_valid = 1'b0;
    dwell_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (start_scan) begin
            load_scan = 1'b1;
            state_d   = SCAN;
          end else begin
            load_direct = 1'b1;
          end
        end else if (consume) begin
          clear_valid = 1'b1;
        end
      end
      SCAN: begin
        if (consume) begin
          if (DWELL == 1) begin
            present = 1'b1;
          end else begin
            clear_valid = 1'b1;
            dwell_load  = 1'b1;
          end
        end else if (!out_valid_q && dwell_done) begin
          present = 1'b1;
        end
        if (present && (beat_q == LAST_BEAT)) state_d = DRAIN;
      end
      DRAIN: begin
        if (consume) begin
          clear_valid = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      beat_q      <= '0;
    end else if (load_direct) begin
      out_q       <= (en_pad && par_ok) ? OUT_W'(onehot(SEL_MAX_W'(sel_pad))) : '0;
      out_valid_q <= 1'b1;
    end else if (load_scan) begin
      out_q       <= OUT_W'(onehot(SEL_MAX_W'(sel_pad)));
      out_valid_q <= 1'b1;
      idx_q       <= sel_pad;
      beat_q      <= (SEL_W+1)'(1);
    end else if (present) begin
      out_q       <= OUT_W'(onehot(SEL_MAX_W'(idx_nxt)));
      out_valid_q <= 1'b1;
      idx_q       <= idx_nxt;
      beat_q      <= beat_q + 1'b1;
    end else if (clear_valid) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad)            err_q <= 1'b0;
    else if (accept && !par_ok) err_q <= 1'b1;
  end

  decod_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk      (clk_pad),
    .rst_n    (rst_n_pad),
    .load     (dwell_load),
    .load_val (DWELL_LD),
    .dec      ((state_q == SCAN) && !out_valid_q),
    .done     (dwell_done)
  );

  assign out_pad       = out_q;
  assign out_valid_pad = out_valid_q;
  assign busy_pad      = (state_q != IDLE);
  assign err_pad       = err_q;

endmodule

// File: tb/tb_decod_seq_reg.sv
// Self-checking bench for decod_seq_reg: stream-level reference model plus directed literal checks.
module tb_decod_seq_reg;

  localparam int SEL_W = 4;
  localparam int OUT_W = 16;
  localparam int DWELL = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SEL_W-1:0] sel = '0;
  logic             sel_par = 1'b0;
  logic             en = 1'b0;
  logic             mode = 1'b0;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decod_seq_reg #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk_pad       (clk),
    .rst_n_pad     (rst_n),
    .in_valid_pad  (in_valid),
    .in_ready_pad  (in_ready),
    .sel_pad       (sel),
`ifdef DECOD_PARITY_EN
    .sel_par_pad   (sel_par),
`endif
    .en_pad        (en),
    .mode_pad      (mode),
    .out_pad       (out),
    .out_valid_pad (out_valid),
    .out_ready_pad (out_ready),
    .busy_pad      (busy),
    .err_pad       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a stream of beats. A SCAN is "beats left to present" plus the next index.
  logic             m_valid = 1'b0;
  logic [OUT_W-1:0] m_val = '0;
  logic             m_busy = 1'b0;
  logic             m_err = 1'b0;
  int               m_next = 0;
  int               m_left = 0;
  int               m_gap = 0;
  logic             m_rdy, m_cons, m_acc, m_pres, m_par_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_val = '0; m_busy = 1'b0; m_err = 1'b0;
      m_next = 0; m_left = 0; m_gap = 0;
    end else begin
      m_rdy  = !m_busy && (!m_valid || out_ready);
      m_cons = m_valid && out_ready;
      m_acc  = in_valid && m_rdy;
      m_pres = 1'b0;
`ifdef DECOD_PARITY_EN
      m_par_ok = (sel_par == ^sel);
`else
      m_par_ok = 1'b1;
`endif
      if (m_cons) m_valid = 1'b0;
      if (m_busy) begin
        if (m_cons) begin
          if (m_left == 0)     m_busy = 1'b0;
          else if (DWELL == 1) m_pres = 1'b1;
          else                 m_gap  = DWELL - 1;
        end else if (!m_valid && m_gap > 0) begin
          m_gap--;
          if (m_gap == 0) m_pres = 1'b1;
        end
      end else if (m_acc) begin
        if (mode && en && m_par_ok) begin
          m_busy = 1'b1;
          m_next = int'(sel);
          m_left = OUT_W;
          m_pres = 1'b1;
        end else begin
          m_val   = (en && m_par_ok) ? OUT_W'(1 << sel) : '0;
          m_valid = 1'b1;
        end
        if (!m_par_ok) m_err = 1'b1;
      end
      if (m_pres) begin
        m_val   = OUT_W'(1 << m_next);
        m_next  = (m_next + 1) % OUT_W;
        m_left--;
        m_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(!m_busy && (!m_valid || out_ready)));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_busy));
    check("err", 32'(err), 32'(m_err));
    if (m_valid) check("out", 32'(out), 32'(m_val));
    if (out_valid) check("onehot_le1", 32'($countones(out) <= 1), 32'd1);
  end

  task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic e,
                       input logic m, input logic r);
    @(posedge clk); #1;
    in_valid = v; sel = s; en = e; mode = m; out_ready = r; sel_par = ^s;
  endtask

  logic [OUT_W-1:0] exp_v;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // DIRECT single beats
    drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("direct_sel5", 32'(out), 32'h0020);
    check("direct_sel5_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("direct_en0", 32'(out), 32'h0000);
    check("direct_en0_valid", 32'(out_valid), 32'd1);

    // back-to-back DIRECT, one beat per cycle
    for (int i = 0; i <= OUT_W; i++) begin
      if (i < OUT_W) drive(1'b1, SEL_W'(i), 1'b1, 1'b0, 1'b1);
      else           drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (i >= 1) begin
        exp_v = OUT_W'(1 << (i - 1));
        check("b2b_out", 32'(out), 32'(exp_v));
        check("b2b_valid", 32'(out_valid), 32'd1);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // SCAN from 14: wraps 15 -> 0
    drive(1'b1, 4'd14, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < OUT_W; k++) begin
      @(negedge clk);
      exp_v = OUT_W'(1 << ((14 + k) % OUT_W));
      check("scan_out", 32'(out), 32'(exp_v));
      check("scan_busy", 32'(busy), 32'd1);
      check("scan_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("scan_done_busy", 32'(busy), 32'd0);
    check("scan_done_valid", 32'(out_valid), 32'd0);

    // SCAN with backpressure and an ignored request while busy
    drive(1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_frozen", 32'(out), 32'h0004);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < OUT_W; k++) begin
      @(negedge clk);
      exp_v = OUT_W'(1 << ((2 + k) % OUT_W));
      check("bp_resume", 32'(out), 32'(exp_v));
    end
    @(negedge clk);
    check("bp_done_busy", 32'(busy), 32'd0);

    // async reset in the middle of a SCAN
    drive(1'b1, 4'd7, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef DECOD_PARITY_EN
    drive(1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
    sel_par = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("par_out", 32'(out), 32'h0000);
    check("par_valid", 32'(out_valid), 32'd1);
    check("par_busy", 32'(busy), 32'd0);
    check("par_err", 32'(err), 32'd1);
    repeat (5) @(negedge clk);
    check("par_err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("par_err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      sel       = SEL_W'($urandom_range(0, OUT_W - 1));
      en        = ($urandom_range(0, 7) != 0);
      mode      = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sel_par   = (^sel) ^ ($urandom_range(0, 15) == 0);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
